cfa_window_ctrl: RTL and testbench
==================================

# cfa_window_ctrl

Sequencing controller for the CFA demosaic front end. Accepts a raster pixel stream qualified by `pix_valid`/`sof` and drives the `en` input of the 3x3 line/window buffer (12-bit pixels, 108-bit window output). It tracks row and column position and flags the cycles in which the buffer's 3x3 window is fully populated with interior pixels. It tags each valid window with its centre coordinates and Bayer phase for the interpolation stage.

## Interface
- `IMG_W`, 640, active pixels per line (>= 3)
- `IMG_H`, 480, active lines per frame (>= 3)
- `CW`, 12, width of row/column counters; must satisfy 2^CW > max(IMG_W, IMG_H)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pix_valid`  in  1  pixel present on the buffer's `d_in` this cycle
- `sof`  in  1  start of frame; meaningful only when `pix_valid`=1; marks pixel (0,0)
- `buf_en`  out  1  enable to the window buffer `en` port; combinational
- `win_valid`  out  1  window buffer output holds a complete interior 3x3 window; registered
- `ctr_row`  out  CW  centre row of current window; registered
- `ctr_col`  out  CW  centre column of current window; registered
- `bayer_phase`  out  2  {ctr_row[0], ctr_col[0]}: 00=R, 01=Gr, 10=Gb, 11=B (RGGB); registered
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted
- `frame_abort`  out  1  one-cycle pulse when `sof` arrives mid-frame

## Operation
- FSM states:
  - IDLE: reset state.
  - ACTIVE
  - DONE: lasts one cycle.
- IDLE:
  - `buf_en` = `pix_valid & sof`.
  - Accepted `sof` pixel is (0,0): `in_col`<=1, `in_row`<=0, go to ACTIVE.
  - `pix_valid` without `sof` is ignored (`buf_en`=0).
- ACTIVE:
  - `buf_en` = `pix_valid`.
  - Each accepted pixel at (`in_row`,`in_col`) advances `in_col`.
  - At `in_col`=IMG_W-1, `in_col` wraps to 0 and `in_row` increments.
- End of frame: accepting pixel (IMG_H-1, IMG_W-1) moves ACTIVE->DONE and counters clear to 0.
- DONE:
  - `buf_en` = `pix_valid & sof`; `frame_done`=1.
  - Next state is ACTIVE if `sof` is accepted this cycle (pixel (0,0) taken), else IDLE.
- `sof` in ACTIVE:
  - Accepted pixel is (0,0) of a new frame and counters restart.
  - `frame_abort` pulses next cycle; state stays ACTIVE.
  - No `win_valid` is generated for that pixel.
- Window qualification:
  - An accepted pixel at (r,c) with r>=2 and c>=2 completes the window centred at (r-1, c-1).
  - `win_valid` pulses with `ctr_row`=r-1 and `ctr_col`=c-1.
- Border windows are never flagged:
  - Centres are rows 1..IMG_H-2 and columns 1..IMG_W-2.
  - Exactly (IMG_H-2)*(IMG_W-2) `win_valid` pulses per complete frame.
- Gaps (`pix_valid`=0): counters hold, `buf_en`=0, `win_valid`=0.
- `ctr_row`/`ctr_col`/`bayer_phase` update only when `win_valid` asserts and hold otherwise.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; counters 0; `win_valid`, `ctr_row`, `ctr_col`, `bayer_phase`, `frame_done`, `frame_abort` all 0.
- `buf_en` is combinational from `pix_valid`/`sof`/state and has no register delay. The buffer samples on the same edge as the controller counters.
- `win_valid` and its tags appear one cycle after the accepting edge. They are aligned with the buffer output updated on that edge.
- `frame_done` asserts the cycle after the last pixel is accepted, coincident with the final `win_valid` pulse.
- Back-to-back frames are supported: `sof` may arrive in the DONE cycle with no idle cycle.
- Reset mid-frame discards all position state. The next frame requires `sof`.
- Throughput: one pixel per cycle sustained; no backpressure.

## Test plan
- IMG_W=4, IMG_H=3, one frame of 12 contiguous pixels starting with `sof`:
  - `win_valid` pulses exactly twice, centres (1,1) and (1,2), `bayer_phase` 11 then 10.
  - `frame_done` pulses once, coincident with the second pulse.
- Same frame with `pix_valid` low every other cycle: identical window sequence, `buf_en` low in every gap, counters hold.
- Pixels with `pix_valid`=1 but no `sof` from reset: `buf_en`=0, no `win_valid`, state stays IDLE until `sof`.
- `sof` reasserted at pixel 7 of an IMG_W=4, IMG_H=3 frame:
  - `frame_abort` pulses one cycle later.
  - Counting restarts at (0,0); no `frame_done` for the aborted frame.
  - The new frame yields 2 windows.
- Two back-to-back frames with `sof` on the cycle immediately after the last pixel: 4 `win_valid` total, two `frame_done` pulses, no dropped pixel.
- `rst` asserted low mid-frame (after pixel 9):
  - All outputs 0 immediately (asynchronously).
  - After release, the frame restarted with `sof` produces exactly 2 windows.

Source files
------------

// File: rtl/cfa_window_ctrl.sv
// Sequencing controller for the CFA 3x3 window buffer: gates the buffer enable,
// tracks raster position and tags each complete interior window with centre and Bayer phase.
module cfa_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic          sof,
  output logic          buf_en,
  output logic          win_valid,
  output logic [CW-1:0] ctr_row,
  output logic [CW-1:0] ctr_col,
  output logic [1:0]    bayer_phase,
  output logic          frame_done,
  output logic          frame_abort
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  state_t        state;
  logic [CW-1:0] in_row;
  logic [CW-1:0] in_col;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_hit;

  // Outside ACTIVE only a start-of-frame pixel may enter the buffer.
  always_comb begin
    buf_en = (state == ACTIVE) ? pix_valid : (pix_valid & sof);
  end

  // The pixel at (r,c) closes the window whose centre lags by one row and column.
  assign win_row = in_row - 1'b1;
  assign win_col = in_col - 1'b1;
  assign win_hit = (in_row >= TWO) && (in_col >= TWO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      in_row      <= '0;
      in_col      <= '0;
      win_valid   <= 1'b0;
      ctr_row     <= '0;
      ctr_col     <= '0;
      bayer_phase <= 2'b00;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      win_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (buf_en) begin
        if (sof) begin
          // Accepted sof is always pixel (0,0); mid-frame it abandons the old frame.
          frame_abort <= (state == ACTIVE);
          in_row      <= '0;
          in_col      <= CW'(1);
          state       <= ACTIVE;
        end else begin
          if (win_hit) begin
            win_valid   <= 1'b1;
            ctr_row     <= win_row;
            ctr_col     <= win_col;
            bayer_phase <= {win_row[0], win_col[0]};
          end
          if (in_col == LAST_COL) begin
            in_col <= '0;
            if (in_row == LAST_ROW) begin
              in_row     <= '0;
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              in_row <= in_row + 1'b1;
            end
          end else begin
            in_col <= in_col + 1'b1;
          end
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cfa_window_ctrl.sv
// Bench for cfa_window_ctrl on a 4x3 image: directed scenarios plus a random
// pixel stream compared cycle by cycle with a frame-index reference model.
module tb_cfa_window_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          pix_valid;
  logic          sof;
  logic          buf_en;
  logic          win_valid;
  logic [CW-1:0] ctr_row;
  logic [CW-1:0] ctr_col;
  logic [1:0]    bayer_phase;
  logic          frame_done;
  logic          frame_abort;

  cfa_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sof(sof), .buf_en(buf_en),
    .win_valid(win_valid), .ctr_row(ctr_row), .ctr_col(ctr_col),
    .bayer_phase(bayer_phase), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame membership plus linear pixel index within the frame.
  bit m_in_frame;
  int m_k;
  bit e_buf_en, e_win, e_done, e_abort;
  int e_row, e_col, e_phase;

  // Observations gathered per cycle by run_cyc.
  logic [9:0] win_q[$];
  bit obs_buf_en;
  int n_done, n_done_win, n_abort, n_gap_en, n_buf_en, cyc, abort_cyc, acc_cyc;

  task automatic model_reset();
    m_in_frame = 0; m_k = 0;
    e_win = 0; e_done = 0; e_abort = 0; e_row = 0; e_col = 0; e_phase = 0;
  endtask

  task automatic model_step(input bit v, input bit s);
    int r, c;
    e_win = 0; e_done = 0; e_abort = 0;
    e_buf_en = m_in_frame ? v : (v & s);
    if (e_buf_en) begin
      if (s) begin
        e_abort = m_in_frame;
        m_in_frame = 1;
        m_k = 1;
      end else begin
        r = m_k / W;
        c = m_k % W;
        if (r >= 2 && c >= 2) begin
          e_win = 1; e_row = r - 1; e_col = c - 1;
          e_phase = (e_row % 2) * 2 + (e_col % 2);
        end
        m_k++;
        if (m_k == W * H) begin
          m_in_frame = 0; m_k = 0; e_done = 1;
        end
      end
    end
  endtask

  task automatic clear_obs();
    win_q.delete();
    n_done = 0; n_done_win = 0; n_abort = 0; n_gap_en = 0; n_buf_en = 0;
    cyc = 0; abort_cyc = -1; acc_cyc = -1;
  endtask

  // Drive one cycle (called at posedge+1), sample buf_en mid-cycle, outputs after the edge.
  task automatic run_cyc(input bit v, input bit s);
    pix_valid = v; sof = s;
    #4;
    obs_buf_en = buf_en;
    model_step(v, s);
    if (obs_buf_en && s) acc_cyc = cyc;
    @(posedge clk); #1;
    if (win_valid) win_q.push_back({ctr_row, ctr_col, bayer_phase});
    if (frame_done) n_done++;
    if (frame_done && win_valid) n_done_win++;
    if (frame_abort) begin n_abort++; abort_cyc = cyc; end
    if (!v && obs_buf_en) n_gap_en++;
    if (obs_buf_en) n_buf_en++;
    cyc++;
  endtask

  task automatic do_reset();
    pix_valid = 0; sof = 0;
    rst = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic run_frame(input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      run_cyc(1'b1, i == 0);
      if (gaps) run_cyc(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1; pix_valid = 0; sof = 0;
    #1 rst = 0;
    #2;
    checks++;
    if ({win_valid, ctr_row, ctr_col, bayer_phase, frame_done, frame_abort, buf_en} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0",
               {win_valid, ctr_row, ctr_col, bayer_phase, frame_done, frame_abort, buf_en});
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_single_frame();
    do_reset(); clear_obs();
    run_frame(1'b0);
    run_cyc(0, 0); run_cyc(0, 0);
    checks++;
    if (win_q.size() != 2) begin errors++; $display("FAIL single_win_count got %0d expected 2", win_q.size()); end
    else begin
      checks++;
      if (win_q[0] !== {4'd1, 4'd1, 2'b11}) begin errors++; $display("FAIL single_win0 got %h expected %h", win_q[0], {4'd1, 4'd1, 2'b11}); end
      checks++;
      if (win_q[1] !== {4'd1, 4'd2, 2'b10}) begin errors++; $display("FAIL single_win1 got %h expected %h", win_q[1], {4'd1, 4'd2, 2'b10}); end
    end
    checks++;
    if (n_done != 1 || n_done_win != 1) begin errors++; $display("FAIL single_done got %0d/%0d expected 1/1", n_done, n_done_win); end
  endtask

  task automatic test_gaps();
    do_reset(); clear_obs();
    run_frame(1'b1);
    run_cyc(0, 0);
    checks++;
    if (win_q.size() != 2) begin errors++; $display("FAIL gap_win_count got %0d expected 2", win_q.size()); end
    else begin
      checks++;
      if (win_q[0] !== {4'd1, 4'd1, 2'b11} || win_q[1] !== {4'd1, 4'd2, 2'b10}) begin
        errors++; $display("FAIL gap_win_seq got %h %h expected 1b 12", win_q[0], win_q[1]);
      end
    end
    checks++;
    if (n_gap_en != 0) begin errors++; $display("FAIL gap_buf_en got %0d expected 0", n_gap_en); end
    checks++;
    if (ctr_row !== 4'd1 || ctr_col !== 4'd2 || bayer_phase !== 2'b10) begin
      errors++; $display("FAIL gap_hold got %0d,%0d,%b expected 1,2,10", ctr_row, ctr_col, bayer_phase);
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL gap_done got %0d expected 1", n_done); end
  endtask

  task automatic test_no_sof();
    do_reset(); clear_obs();
    for (int i = 0; i < 14; i++) run_cyc(1'b1, 1'b0);
    checks++;
    if (n_buf_en != 0 || win_q.size() != 0) begin
      errors++; $display("FAIL nosof_ignored got buf_en=%0d win=%0d expected 0/0", n_buf_en, win_q.size());
    end
    clear_obs();
    run_frame(1'b0);
    run_cyc(0, 0);
    checks++;
    if (win_q.size() != 2 || n_done != 1) begin
      errors++; $display("FAIL nosof_then_frame got win=%0d done=%0d expected 2/1", win_q.size(), n_done);
    end
  endtask

  task automatic test_abort();
    int sof_cyc;
    do_reset(); clear_obs();
    for (int i = 0; i < 7; i++) run_cyc(1'b1, i == 0);
    sof_cyc = cyc;
    for (int i = 0; i < W * H; i++) run_cyc(1'b1, i == 0);
    run_cyc(0, 0); run_cyc(0, 0);
    checks++;
    if (n_abort != 1 || abort_cyc != sof_cyc) begin
      errors++; $display("FAIL abort_pulse got n=%0d at %0d expected 1 at %0d", n_abort, abort_cyc, sof_cyc);
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL abort_done got %0d expected 1", n_done); end
    checks++;
    if (win_q.size() != 2) begin errors++; $display("FAIL abort_wins got %0d expected 2", win_q.size()); end
    else begin
      checks++;
      if (win_q[0] !== {4'd1, 4'd1, 2'b11} || win_q[1] !== {4'd1, 4'd2, 2'b10}) begin
        errors++; $display("FAIL abort_win_seq got %h %h expected 1b 12", win_q[0], win_q[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_obs();
    run_frame(1'b0);
    run_frame(1'b0);
    run_cyc(0, 0); run_cyc(0, 0);
    checks++;
    if (win_q.size() != 4) begin errors++; $display("FAIL b2b_wins got %0d expected 4", win_q.size()); end
    checks++;
    if (n_done != 2 || n_done_win != 2) begin errors++; $display("FAIL b2b_done got %0d/%0d expected 2/2", n_done, n_done_win); end
    checks++;
    if (n_buf_en != 2 * W * H || n_abort != 0) begin
      errors++; $display("FAIL b2b_accepted got %0d abort %0d expected %0d/0", n_buf_en, n_abort, 2 * W * H);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_obs();
    for (int i = 0; i < 9; i++) run_cyc(1'b1, i == 0);
    pix_valid = 0; sof = 0;
    #3 rst = 0;
    #1;
    checks++;
    if ({win_valid, ctr_row, ctr_col, bayer_phase, frame_done, frame_abort, buf_en} !== '0) begin
      errors++;
      $display("FAIL midreset_async got %b expected 0",
               {win_valid, ctr_row, ctr_col, bayer_phase, frame_done, frame_abort, buf_en});
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    clear_obs();
    run_frame(1'b0);
    run_cyc(0, 0);
    checks++;
    if (win_q.size() != 2 || n_done != 1) begin
      errors++; $display("FAIL midreset_frame got win=%0d done=%0d expected 2/1", win_q.size(), n_done);
    end
  endtask

  task automatic test_random();
    bit v, s;
    do_reset(); clear_obs();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      s = v && (($urandom % 16) == 0);
      run_cyc(v, s);
      checks++;
      if (obs_buf_en !== e_buf_en) begin errors++; $display("FAIL rnd_buf_en cyc %0d got %b expected %b", i, obs_buf_en, e_buf_en); end
      checks++;
      if (win_valid !== e_win) begin errors++; $display("FAIL rnd_win_valid cyc %0d got %b expected %b", i, win_valid, e_win); end
      checks++;
      if (ctr_row !== CW'(e_row) || ctr_col !== CW'(e_col) || bayer_phase !== 2'(e_phase)) begin
        errors++; $display("FAIL rnd_tags cyc %0d got %0d,%0d,%0d expected %0d,%0d,%0d",
                           i, ctr_row, ctr_col, bayer_phase, e_row, e_col, e_phase);
      end
      checks++;
      if (frame_done !== e_done || frame_abort !== e_abort) begin
        errors++; $display("FAIL rnd_pulses cyc %0d got done=%b abort=%b expected %b/%b",
                           i, frame_done, frame_abort, e_done, e_abort);
      end
    end
  endtask

  initial begin
    rst = 1; pix_valid = 0; sof = 0;
    test_reset();
    test_single_frame();
    test_gaps();
    test_no_sof();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
